// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one I2C write engine among NREQ requesters, with NACK retry and watchdog.
// Grant to GO in 2 cycles; requesters hold iREQ until their one-cycle oDONE/oERR pulse.
module i2c_write_arbiter #(
  parameter int          NREQ      = 3,
  parameter logic [7:0]  DEV_ADDR  = 8'hBA,
  parameter int          MAX_RETRY = 3,
  parameter int          TIMEOUT   = 20000
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [NREQ-1:0]      iREQ,
  input  logic [24*NREQ-1:0]   iREQ_DATA,
  output logic [NREQ-1:0]      oDONE,
  output logic [NREQ-1:0]      oERR,
  output logic                 oBUSY,
  output logic [31:0]          oI2C_DATA,
  output logic                 oI2C_GO,
  input  logic                 iI2C_END,
  input  logic                 iI2C_ACK
);

  localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_WAIT_END, S_CHECK, S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, idx_q, pick;
  logic          pick_vld;
  logic [3:0]    retry_q;
  logic          retry_flag_q;
  logic [15:0]   wd_q;
  logic          ack_q;
  logic [31:0]   data_q;
  logic          timeout;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Reverse scan so the lowest offset from rr_q (highest priority) wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (iREQ[wrap_add(rr_q, k)]) begin
        pick_vld = 1'b1;
        pick     = wrap_add(rr_q, k);
      end
    end
  end

  assign timeout   = (state_q == S_WAIT_END) && !iI2C_END && (wd_q == WD_LAST);
  assign oI2C_DATA = data_q;

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (pick_vld) state_d = S_GRANT;
      S_GRANT:    state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT_END;
      S_WAIT_END: begin
        if (iI2C_END)     state_d = S_CHECK;
        else if (timeout) state_d = S_RELEASE;
      end
      S_CHECK:    state_d = S_RELEASE;
      S_RELEASE:  if (!iI2C_END) state_d = retry_flag_q ? S_GRANT : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oBUSY   = (state_q != S_IDLE);
    oI2C_GO = 1'b0;
    oDONE   = '0;
    oERR    = '0;
    case (state_q)
      S_ISSUE:    oI2C_GO = 1'b1;
      S_WAIT_END: begin
        oI2C_GO = !timeout;
        if (timeout) oERR[idx_q] = 1'b1;
      end
      S_CHECK: begin
        if (!ack_q)                   oDONE[idx_q] = 1'b1;
        else if (retry_q >= RETRY_MAX) oERR[idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // The word is loaded on entry to GRANT so it is already stable for the whole GRANT cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rr_q         <= '0;
      idx_q        <= '0;
      retry_q      <= '0;
      retry_flag_q <= 1'b0;
      wd_q         <= '0;
      ack_q        <= 1'b0;
      data_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            idx_q   <= pick;
            data_q  <= {DEV_ADDR, iREQ_DATA[24*pick +: 24]};
            retry_q <= '0;
          end
        end
        S_GRANT:    retry_flag_q <= 1'b0;
        S_ISSUE:    wd_q <= '0;
        S_WAIT_END: begin
          if (wd_q != '1) wd_q <= wd_q + 16'd1;
          if (iI2C_END)   ack_q <= iI2C_ACK;
        end
        S_CHECK: begin
          if (ack_q && (retry_q < RETRY_MAX)) begin
            retry_q      <= retry_q + 4'd1;
            retry_flag_q <= 1'b1;
          end
        end
        S_RELEASE:  if (!iI2C_END && !retry_flag_q) rr_q <= wrap_add(idx_q, 1);
        default: ;
      endcase
    end
  end

endmodule
